// File: rtl/buf_kernel_ctrl.sv
// Kernel-buffer sequencer: loads NKERN kernel beats and NSEL select beats from the DMA
// stream into the buffer write port, then sweeps read addresses for each compute pass.
module buf_kernel_ctrl #(
  parameter int DATALEN = 64,
  parameter int INDXLEN = 6,
  parameter int NKERN   = 512,
  parameter int NSEL    = 128,
  parameter int RDDEPTH = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               load_start,
  input  logic               pass_start,
  input  logic               s_valid,
  input  logic [DATALEN-1:0] s_data,
  output logic               s_ready,
  output logic               invalid,
  output logic               iskern,
  output logic               issel,
  output logic [DATALEN-1:0] indata,
  input  logic               rd_en,
  output logic [INDXLEN-1:0] outaddr,
  output logic               rd_valid,
  output logic               rd_last,
  output logic               loaded,
  output logic               busy,
  output logic [2:0]         dbg_state
);

  localparam int KW = $clog2(NKERN + 1);
  localparam int SW = $clog2(NSEL + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_K = 3'd1,
    S_LOAD_S = 3'd2,
    S_READY  = 3'd3,
    S_READ   = 3'd4
  } state_t;

  state_t               r_state;
  logic [KW-1:0]        r_kcnt;
  logic [SW-1:0]        r_scnt;
  logic [INDXLEN-1:0]   r_acnt;
  logic                 r_s_ready;
  logic                 r_invalid;
  logic                 r_iskern;
  logic                 r_issel;
  logic [DATALEN-1:0]   r_indata;
  logic                 r_rd_valid;
  logic                 r_rd_last;
  logic                 r_loaded;
  logic                 r_busy;
  logic                 w_accept;
  logic                 w_rd_end;

  // Stream handshake: a beat transfers on any rising edge where s_valid && s_ready;
  // s_ready is only high in the two load states, so the source is never drained elsewhere.
  assign w_accept = s_valid && r_s_ready;
  assign w_rd_end = (r_acnt == INDXLEN'(RDDEPTH - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_kcnt     <= '0;
      r_scnt     <= '0;
      r_acnt     <= '0;
      r_s_ready  <= 1'b0;
      r_invalid  <= 1'b0;
      r_iskern   <= 1'b0;
      r_issel    <= 1'b0;
      r_indata   <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_loaded   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_invalid  <= 1'b0;
      r_iskern   <= 1'b0;
      r_issel    <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load_start) begin
            r_state   <= S_LOAD_K;
            r_kcnt    <= '0;
            r_scnt    <= '0;
            r_loaded  <= 1'b0;
            r_s_ready <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        S_LOAD_K: begin
          if (w_accept) begin
            r_invalid <= 1'b1;
            r_iskern  <= 1'b1;
            r_indata  <= s_data;
            r_kcnt    <= r_kcnt + KW'(1);
            if (r_kcnt == KW'(NKERN - 1)) r_state <= S_LOAD_S;
          end
        end
        S_LOAD_S: begin
          if (w_accept) begin
            r_invalid <= 1'b1;
            r_issel   <= 1'b1;
            r_indata  <= s_data;
            r_scnt    <= r_scnt + SW'(1);
            // loaded rises together with the final select write strobe
            if (r_scnt == SW'(NSEL - 1)) begin
              r_state   <= S_READY;
              r_s_ready <= 1'b0;
              r_busy    <= 1'b0;
              r_loaded  <= 1'b1;
            end
          end
        end
        S_READY: begin
          if (load_start) begin
            r_state   <= S_LOAD_K;
            r_kcnt    <= '0;
            r_scnt    <= '0;
            r_loaded  <= 1'b0;
            r_s_ready <= 1'b1;
            r_busy    <= 1'b1;
          end else if (pass_start) begin
            r_state <= S_READ;
            r_acnt  <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_READ: begin
          // The buffer answers one cycle later, so valid/last trail the issued address.
          if (rd_en) begin
            r_rd_valid <= 1'b1;
            r_rd_last  <= w_rd_end;
            if (w_rd_end) begin
              r_state <= S_READY;
              r_acnt  <= '0;
              r_busy  <= 1'b0;
            end else begin
              r_acnt <= r_acnt + INDXLEN'(1);
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_s_ready <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready   = r_s_ready;
  assign invalid   = r_invalid;
  assign iskern    = r_iskern;
  assign issel     = r_issel;
  assign indata    = r_indata;
  assign outaddr   = r_acnt;
  assign rd_valid  = r_rd_valid;
  assign rd_last   = r_rd_last;
  assign loaded    = r_loaded;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_buf_kernel_ctrl.sv
// Bench for buf_kernel_ctrl: scoreboarded load sequences plus a vector table for read passes.
module tb_buf_kernel_ctrl;

  localparam int NK = 512;
  localparam int NS = 128;
  localparam int DL = 64;
  localparam int IL = 6;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          load_start = 1'b0;
  logic          pass_start = 1'b0;
  logic          s_valid = 1'b0;
  logic [DL-1:0] s_data = '0;
  logic          s_ready;
  logic          invalid;
  logic          iskern;
  logic          issel;
  logic [DL-1:0] indata;
  logic          rd_en = 1'b0;
  logic [IL-1:0] outaddr;
  logic          rd_valid;
  logic          rd_last;
  logic          loaded;
  logic          busy;
  logic [2:0]    dbg_state;

  int checks = 0;
  int failures = 0;

  // {iskern expected, data}
  logic [DL:0] exp_q[$];

  typedef struct {
    logic          ld;
    logic          ps;
    logic          en;
    logic          sv;
    logic [IL-1:0] addr;
    logic          vld;
    logic          last;
    logic          bsy;
    logic          ldd;
    logic          srdy;
  } vec_t;
  vec_t vt[$];

  buf_kernel_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .load_start (load_start),
    .pass_start (pass_start),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .invalid    (invalid),
    .iskern     (iskern),
    .issel      (issel),
    .indata     (indata),
    .rd_en      (rd_en),
    .outaddr    (outaddr),
    .rd_valid   (rd_valid),
    .rd_last    (rd_last),
    .loaded     (loaded),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic ld, input logic ps, input logic en, input logic sv,
                              input logic [IL-1:0] addr, input logic vld, input logic last,
                              input logic bsy, input logic ldd, input logic srdy);
    vt.push_back('{ld, ps, en, sv, addr, vld, last, bsy, ldd, srdy});
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_s_ready"},  64'(s_ready),   64'd0);
    chk({tag, "_invalid"},  64'(invalid),   64'd0);
    chk({tag, "_iskern"},   64'(iskern),    64'd0);
    chk({tag, "_issel"},    64'(issel),     64'd0);
    chk({tag, "_indata"},   indata,         64'd0);
    chk({tag, "_outaddr"},  64'(outaddr),   64'd0);
    chk({tag, "_rd_valid"}, 64'(rd_valid),  64'd0);
    chk({tag, "_rd_last"},  64'(rd_last),   64'd0);
    chk({tag, "_loaded"},   64'(loaded),    64'd0);
    chk({tag, "_busy"},     64'(busy),      64'd0);
    chk({tag, "_state"},    64'(dbg_state), 64'd0);
  endtask

  task automatic apply_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      load_start = vt[i].ld;
      pass_start = vt[i].ps;
      rd_en      = vt[i].en;
      s_valid    = vt[i].sv;
      step();
      chk($sformatf("vec%0d_outaddr", i),  64'(outaddr),  64'(vt[i].addr));
      chk($sformatf("vec%0d_rd_valid", i), 64'(rd_valid), 64'(vt[i].vld));
      chk($sformatf("vec%0d_rd_last", i),  64'(rd_last),  64'(vt[i].last));
      chk($sformatf("vec%0d_busy", i),     64'(busy),     64'(vt[i].bsy));
      chk($sformatf("vec%0d_loaded", i),   64'(loaded),   64'(vt[i].ldd));
      chk($sformatf("vec%0d_s_ready", i),  64'(s_ready),  64'(vt[i].srdy));
      chk($sformatf("vec%0d_invalid", i),  64'(invalid),  64'd0);
    end
    load_start = 1'b0;
    pass_start = 1'b0;
    rd_en      = 1'b0;
    s_valid    = 1'b0;
  endtask

  // driver: load_start pulse, then n_beats stream beats; the scoreboard pops one entry per strobe
  task automatic do_load(input int n_beats, input bit toggle, input int ls_at);
    int  k;
    int  cyc;
    bit  drove;
    bit  early;
    logic [DL:0] e;
    load_start = 1'b1;
    s_valid    = 1'b0;
    step();
    chk("load_busy",    64'(busy),    64'd1);
    chk("load_s_ready", 64'(s_ready), 64'd1);
    chk("load_loaded",  64'(loaded),  64'd0);
    load_start = 1'b0;
    k = 0;
    cyc = 0;
    early = 1'b0;
    while (k < n_beats) begin
      drove      = !(toggle && cyc[0]);
      load_start = (k == ls_at);
      s_valid    = drove;
      s_data     = drove ? DL'(k) : {32'hdead_beef, 32'(cyc)};
      if (drove) begin
        exp_q.push_back({(k < NK), DL'(k)});
        k++;
      end
      step();
      chk($sformatf("strobe_c%0d", cyc), 64'(invalid), 64'(drove));
      if (invalid) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("unexpected_write_c%0d", cyc), 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("iskern_c%0d", cyc), 64'(iskern), 64'(e[DL]));
          chk($sformatf("issel_c%0d", cyc),  64'(issel),  64'(!e[DL]));
          chk($sformatf("indata_c%0d", cyc), indata,      e[DL-1:0]);
        end
      end
      if (k < n_beats && loaded) early = 1'b1;
      cyc++;
    end
    s_valid    = 1'b0;
    load_start = 1'b0;
    if (n_beats == NK + NS) begin
      chk("done_loaded",    64'(loaded),       64'd1);
      chk("done_busy",      64'(busy),         64'd0);
      chk("done_s_ready",   64'(s_ready),      64'd0);
      chk("done_no_early",  64'(early),        64'd0);
      chk("done_q_empty",   64'(exp_q.size()), 64'd0);
      chk("done_cycles",    64'(cyc),          toggle ? 64'(2 * (NK + NS) - 1) : 64'(NK + NS));
    end
  endtask

  initial begin
    int seg_idle;
    int seg_pass;
    int seg_stall;
    int seg_both;
    int seg_end;
    logic [IL-1:0] a;
    logic en;

    // vector table
    seg_idle = vt.size();
    add(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    seg_pass = vt.size();
    add(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 16; k++)
      add(1'b0, 1'b0, 1'b1, 1'b0, IL'(k % 16), 1'b1, (k == 16), (k < 16), 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    seg_stall = vt.size();
    add(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    a = '0;
    for (int c = 0; c < 20; c++) begin
      // stalls while addresses 3 and 9 are presented
      en = !(c == 3 || c == 4 || c == 11 || c == 12);
      if (en && a == 6'd15) begin
        add((c == 4), (c == 6), en, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        a = '0;
      end else begin
        if (en) a = a + 6'd1;
        add((c == 4), (c == 6), en, 1'b0, a, en, 1'b0, 1'b1, 1'b1, 1'b0);
      end
    end
    add(1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    seg_both = vt.size();
    add(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    seg_end = vt.size();

    // reset state
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rstn = 1'b1;

    apply_vecs(seg_idle, seg_pass);

    do_load(NK + NS, 1'b0, -1);
    apply_vecs(seg_pass, seg_stall);
    apply_vecs(seg_pass, seg_stall);
    apply_vecs(seg_stall, seg_both);

    apply_vecs(seg_both, seg_end);
    do_load(NK + NS, 1'b1, 550);

    // asynchronous reset in the middle of the kernel phase
    do_load(300, 1'b0, -1);
    chk("pre_reset_invalid", 64'(invalid), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("midload_reset");
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    do_load(NK + NS, 1'b0, -1);
    apply_vecs(seg_pass, seg_stall);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
